// File: rtl/fasm_fifo.sv
`default_nettype none
// ============================================================================
// fasm_fifo : first-word-fall-through FIFO controller for an external memory
//             (port X write, port A asynchronous read). Macro FASM_FIFO_ERR_EN
//             adds sticky ovf_o/unf_o error flags.           Revision: 1.0
// ============================================================================
module fasm_fifo #(
  parameter int AW     = 5,
  parameter int DW     = 2,
  parameter int AF_LVL = 28
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic [DW-1:0] wdat_i,
  input  logic          wstb_i,
  output logic          wrdy_o,
  output logic [DW-1:0] rdat_o,
  output logic          rvld_o,
  input  logic          rstb_i,
  output logic [AW:0]   lvl_o,
  output logic          aful_o,
  output logic [AW-1:0] mem_xadr_o,
  output logic [DW-1:0] mem_xdat_o,
  output logic          mem_xwre_o,
  output logic [AW-1:0] mem_adr_o,
  input  logic [DW-1:0] mem_dat_i
`ifdef FASM_FIFO_ERR_EN
  ,
  output logic          ovf_o,
  output logic          unf_o
`endif
);

  localparam logic [AW:0] C_ONE    = (AW+1)'(1);
  localparam logic [AW:0] C_AF_LVL = (AW+1)'(AF_LVL);

  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  // Full when the addresses coincide but the write pointer has lapped once more.
  assign w_empty = (wp_q == rp_q);
  assign w_full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);

  assign w_push  = wstb_i && !w_full && !clr_i;
  assign w_pop   = rstb_i && !w_empty && !clr_i;

  assign wrdy_o     = !w_full;
  assign rvld_o     = !w_empty;
  assign lvl_o      = wp_q - rp_q;
  assign aful_o     = (lvl_o >= C_AF_LVL);
  assign rdat_o     = mem_dat_i;
  assign mem_xadr_o = wp_q[AW-1:0];
  assign mem_xdat_o = wdat_i;
  assign mem_xwre_o = w_push;
  assign mem_adr_o  = rp_q[AW-1:0];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (clr_i) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (w_push) wp_d = wp_q + C_ONE;
      if (w_pop)  rp_d = rp_q + C_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

`ifdef FASM_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A flush clears the flags even if an illegal access arrives in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (wstb_i && w_full)  ovf_d = 1'b1;
      if (rstb_i && w_empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fasm_fifo.sv
`default_nettype none
// ============================================================================
// tb_fasm_fifo : directed scoreboard bench for fasm_fifo with a behavioural
//                dual-port memory attached.                  Revision: 1.0
// ============================================================================
module tb_fasm_fifo;
  localparam int AW = 5;
  localparam int DW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clr_i;
  logic [DW-1:0] wdat_i;
  logic          wstb_i;
  logic          wrdy_o;
  logic [DW-1:0] rdat_o;
  logic          rvld_o;
  logic          rstb_i;
  logic [AW:0]   lvl_o;
  logic          aful_o;
  logic [AW-1:0] mem_xadr_o;
  logic [DW-1:0] mem_xdat_o;
  logic          mem_xwre_o;
  logic [AW-1:0] mem_adr_o;
  logic [DW-1:0] mem_dat_i;
`ifdef FASM_FIFO_ERR_EN
  logic          ovf_o;
  logic          unf_o;
  logic          m_ovf;
  logic          m_unf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] sb_q[$];
  logic [AW-1:0] m_wptr;
  logic [AW-1:0] m_rptr;
  logic [DW-1:0] mem [DEPTH];

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (mem_xwre_o) mem[mem_xadr_o] <= mem_xdat_o;
  assign mem_dat_i = mem[mem_adr_o];

  fasm_fifo #(.AW(AW), .DW(DW), .AF_LVL(28)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .wdat_i     (wdat_i),
    .wstb_i     (wstb_i),
    .wrdy_o     (wrdy_o),
    .rdat_o     (rdat_o),
    .rvld_o     (rvld_o),
    .rstb_i     (rstb_i),
    .lvl_o      (lvl_o),
    .aful_o     (aful_o),
    .mem_xadr_o (mem_xadr_o),
    .mem_xdat_o (mem_xdat_o),
    .mem_xwre_o (mem_xwre_o),
    .mem_adr_o  (mem_adr_o),
    .mem_dat_i  (mem_dat_i)
`ifdef FASM_FIFO_ERR_EN
    ,
    .ovf_o      (ovf_o),
    .unf_o      (unf_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    chk("lvl",  32'(lvl_o),  32'(sb_q.size()));
    chk("wrdy", 32'(wrdy_o), 32'(sb_q.size() < DEPTH));
    chk("rvld", 32'(rvld_o), 32'(sb_q.size() != 0));
    chk("aful", 32'(aful_o), 32'(sb_q.size() >= 28));
  endtask

  // One clock of stimulus: drive, check pre-edge outputs, advance model at the edge.
  task automatic cycle(input logic push, input logic pop, input logic clr, input logic [DW-1:0] d);
    logic acc_push;
    logic acc_pop;
    wstb_i = push;
    rstb_i = pop;
    clr_i  = clr;
    wdat_i = d;
    #2;
    acc_push = push && (sb_q.size() < DEPTH) && !clr;
    acc_pop  = pop && (sb_q.size() != 0) && !clr;
    chk_status();
    chk("xwre", 32'(mem_xwre_o), 32'(acc_push));
    chk("xadr", 32'(mem_xadr_o), 32'(m_wptr));
    chk("adr",  32'(mem_adr_o),  32'(m_rptr));
    if (acc_push) chk("xdat", 32'(mem_xdat_o), 32'(d));
    if (acc_pop)  chk("rdat", 32'(rdat_o), 32'(sb_q[0]));
`ifdef FASM_FIFO_ERR_EN
    chk("ovf", 32'(ovf_o), 32'(m_ovf));
    chk("unf", 32'(unf_o), 32'(m_unf));
`endif
    @(posedge clk_i);
`ifdef FASM_FIFO_ERR_EN
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (push && sb_q.size() == DEPTH) m_ovf = 1'b1;
      if (pop && sb_q.size() == 0)      m_unf = 1'b1;
    end
`endif
    if (clr) begin
      sb_q.delete();
      m_wptr = '0;
      m_rptr = '0;
    end else begin
      if (acc_pop) begin
        void'(sb_q.pop_front());
        m_rptr = m_rptr + 1'b1;
      end
      if (acc_push) begin
        sb_q.push_back(d);
        m_wptr = m_wptr + 1'b1;
      end
    end
    #1;
    wstb_i = 1'b0;
    rstb_i = 1'b0;
    clr_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i  = 1'b0;
    clr_i  = 1'b0;
    wstb_i = 1'b0;
    rstb_i = 1'b0;
    wdat_i = '0;
    m_wptr = '0;
    m_rptr = '0;
`ifdef FASM_FIFO_ERR_EN
    m_ovf = 1'b0;
    m_unf = 1'b0;
`endif
    repeat (2) @(posedge clk_i);
    #1;
    chk_status();
    chk("rst_xwre", 32'(mem_xwre_o), 32'(0));
    chk("rst_xadr", 32'(mem_xadr_o), 32'(0));
    chk("rst_adr",  32'(mem_adr_o),  32'(0));
    rst_i = 1'b1;

    // Basic fall-through ordering.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 2'(i));
    #2;
    chk("lvl4", 32'(lvl_o), 32'(4));
    chk("head0", 32'(rdat_o), 32'(0));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 2'(0));
    #2;
    chk("lvl_empty", 32'(lvl_o), 32'(0));
    chk("rvld_empty", 32'(rvld_o), 32'(0));

    // Fill to full, then attempt an overflow push.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 2'(i % 4));
    #2;
    chk("lvl_full", 32'(lvl_o), 32'(32));
    chk("wrdy_full", 32'(wrdy_o), 32'(0));
    cycle(1'b1, 1'b0, 1'b0, 2'(3));
    #2;
    chk("lvl_ovf", 32'(lvl_o), 32'(32));

    // Push+pop at full: only the pop lands; then both land.
    cycle(1'b1, 1'b1, 1'b0, 2'(1));
    #2;
    chk("lvl31a", 32'(lvl_o), 32'(31));
    cycle(1'b1, 1'b1, 1'b0, 2'(2));
    #2;
    chk("lvl31b", 32'(lvl_o), 32'(31));
    while (sb_q.size() != 0) cycle(1'b0, 1'b1, 1'b0, 2'(0));

    // Streaming across several pointer wraps at level 1.
    cycle(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
    for (int i = 1; i < 100; i++) cycle(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)));
    cycle(1'b0, 1'b1, 1'b0, 2'(0));

    // Underflow attempt, then flush with a push in the same cycle.
    cycle(1'b0, 1'b1, 1'b0, 2'(0));
    cycle(1'b1, 1'b0, 1'b1, 2'(2));
    #2;
    chk("lvl_clr", 32'(lvl_o), 32'(0));
    cycle(1'b0, 1'b0, 1'b0, 2'(0));

    // Asynchronous reset between edges while data is queued.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 2'((i + 1) % 4));
    rst_i = 1'b0;
    #1;
    chk("arst_rvld", 32'(rvld_o), 32'(0));
    chk("arst_lvl",  32'(lvl_o),  32'(0));
    chk("arst_wrdy", 32'(wrdy_o), 32'(1));
    sb_q.delete();
    m_wptr = '0;
    m_rptr = '0;
`ifdef FASM_FIFO_ERR_EN
    m_ovf = 1'b0;
    m_unf = 1'b0;
`endif
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 2'(3));
    cycle(1'b1, 1'b0, 1'b0, 2'(0));
    cycle(1'b1, 1'b0, 1'b0, 2'(2));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 2'(0));
    #2;
    chk("final_lvl", 32'(lvl_o), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fasm_fifo.md
# fasm_fifo

Synchronous FIFO controller that wraps a single-clock dual-port memory block (one write/read port X, one asynchronous read-only port A) to form a first-word-fall-through queue. Sits directly upstream of the memory: it generates the write address, write data and write enable for port X and the read address for port A, and presents the head word from port A to the consumer. Depth is 2^AW words; storage itself lives in the external memory block.

## Interface
Parameters:
- AW, 5, address width; FIFO depth = 2^AW words (32)
- DW, 2, data width
- AF_LVL, 28, almost-full threshold; aful_o asserted when level >= AF_LVL

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-low
- clr_i  in  1  synchronous flush; pointers and level to zero
- wdat_i  in  DW  push data
- wstb_i  in  1  push request
- wrdy_o  out  1  space available (not full)
- rdat_o  out  DW  head-of-queue data, valid when rvld_o
- rvld_o  out  1  queue not empty
- rstb_i  in  1  pop request
- lvl_o  out  AW+1  current occupancy, 0..2^AW
- aful_o  out  1  level >= AF_LVL
- mem_xadr_o  out  AW  memory port X address (write pointer)
- mem_xdat_o  out  DW  memory port X write data (= wdat_i)
- mem_xwre_o  out  1  memory port X write enable
- mem_adr_o  out  AW  memory port A address (read pointer)
- mem_dat_i  in  DW  memory port A read data (asynchronous)

## Operation
- Pointers wp, rp are AW+1 bits; low AW bits address memory; MSB is wrap flag.
- Empty: wp == rp. Full: low bits equal, MSBs differ. lvl_o = wp - rp modulo 2^(AW+1).
- Push accepted: wstb_i && wrdy_o. mem_xwre_o = wstb_i && wrdy_o (combinational); wp increments on clock edge.
- Pop accepted: rstb_i && rvld_o. rp increments on clock edge.
- rdat_o = mem_dat_i (head word at mem_adr_o = rp[AW-1:0]); no extra register.
- Push when full: ignored, no write, wp unchanged. Pop when empty: ignored.
- Simultaneous push and pop: both accepted if individually legal; level unchanged. When full, pop accepted, push rejected same cycle (wrdy_o reflects pre-edge state). When empty, push accepted, pop ignored.
- Pointers wrap naturally past 2^AW-1 to 0 in low bits, MSB toggles.
- clr_i has priority over push/pop in same cycle: wp = rp = 0, no write issued (mem_xwre_o forced 0 while clr_i high).
- Reset (rst_i low, any time incl. mid-burst): wp = rp = 0 immediately; memory contents not cleared.
- Reset values: wrdy_o=1, rvld_o=0, lvl_o=0, aful_o=0 (AF_LVL>0), mem_xadr_o=0, mem_adr_o=0, mem_xwre_o=0.

## Timing
- Push latency: word written at edge N is visible on rdat_o with rvld_o=1 after edge N (next cycle) when queue was empty.
- Pop: rdat_o advances to next word combinationally after the popping edge.
- lvl_o, aful_o, wrdy_o, rvld_o derived combinationally from registered pointers; change only after clock edges, reset, or (for error flags) as below.
- Sustained throughput one push and one pop per cycle.
- mem_xwre_o, mem_xdat_o, mem_xadr_o are valid in the same cycle as the accepted push, sampled by memory on the same edge.

## Configuration
- FASM_FIFO_ERR_EN defined: adds outputs ovf_o and unf_o (1 bit each). ovf_o sets on edge where wstb_i && !wrdy_o; unf_o sets on edge where rstb_i && !rvld_o. Both sticky; cleared by reset or clr_i (clr_i wins over set in same cycle). Reset value 0.
- Not defined: ports absent; overflow/underflow attempts silently ignored as above.

## Test plan
- Reset then push 0,1,2,3 on consecutive cycles with rstb_i=0 -> lvl_o=4, rvld_o=1, rdat_o=0; pop 4 times -> rdat_o 0,1,2,3 in order, then rvld_o=0, lvl_o=0.
- Push 32 words with pattern i%4 -> wrdy_o=0, lvl_o=32, aful_o high from level 28; 33rd push produces no mem_xwre_o, lvl_o stays 32 (ovf_o=1 with FASM_FIFO_ERR_EN).
- At full, assert wstb_i and rstb_i together -> pop accepted, push rejected, lvl_o=31; next cycle both -> both accepted, lvl_o=31.
- Stream 100 words with push and pop every cycle after first push -> output order matches input across multiple pointer wraps, lvl_o constant 1.
- Pop while empty -> no change to rp, lvl_o=0 (unf_o=1 with macro); then clr_i high with wstb_i high -> no write, lvl_o=0, flags cleared.
- Push 10 words, drop rst_i mid-cycle between edges -> rvld_o=0, lvl_o=0, wrdy_o=1 immediately; after release, push 3 -> read back exactly those 3.
